// File: rtl/rsa_uart_pkg.sv
// rsa_uart_pkg: FSM/phase encodings and UART register map shared by the RSA UART bridge.
package rsa_uart_pkg;
  typedef enum logic [2:0] {
    POLL_RX  = 3'd0,
    READ_RX  = 3'd1,
    CALC     = 3'd2,
    POLL_TX  = 3'd3,
    WRITE_TX = 3'd4
  } state_t;
  typedef enum logic [1:0] {PH_N = 2'd0, PH_D = 2'd1, PH_DATA = 2'd2} phase_t;
  localparam logic [4:0] RX_ADDR = 5'd0;
  localparam logic [4:0] TX_ADDR = 5'd4;
  localparam logic [4:0] STATUS_ADDR = 5'd8;
  localparam int RX_OK = 7;
  localparam int TX_OK = 6;
endpackage

// File: rtl/rsa_uart_bridge_if.sv
// rsa_uart_bridge_if: Avalon-MM link between the bridge (master) and the UART (slave).
interface rsa_uart_bridge_if;
  logic [4:0] address;
  logic read;
  logic write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic waitrequest;
  modport master(output address, read, write, writedata, input readdata, waitrequest);
  modport slave(input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/rsa_avm_port.sv
// rsa_avm_port: single-outstanding Avalon-MM request registers; a request holds until accepted.
module rsa_avm_port
  import rsa_uart_pkg::*;
#(
  parameter logic [4:0] RST_ADDR = STATUS_ADDR
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  rsa_uart_bridge_if.master avm,
  input  logic              load,
  input  logic              nxt_read,
  input  logic              nxt_write,
  input  logic [4:0]        nxt_addr,
  input  logic [31:0]       nxt_wdata,
  output logic              accept
);
  logic read_q, read_d, write_q, write_d;
  logic [4:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  always_comb begin
    accept  = (read_q | write_q) & ~avm.waitrequest;
    read_d  = load ? nxt_read : read_q;
    write_d = load ? nxt_write : write_q;
    addr_d  = load ? nxt_addr : addr_q;
    wdata_d = load ? nxt_wdata : wdata_q;
  end
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      read_q  <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= RST_ADDR;
      wdata_q <= '0;
    end else begin
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign avm.read      = read_q;
  assign avm.write     = write_q;
  assign avm.address   = addr_q;
  assign avm.writedata = wdata_q;
endmodule

// File: rtl/rsa_uart_bridge.sv
// rsa_uart_bridge: loads N, D and data blocks from a UART, runs the modexp core, sends the result back.
// Define RSA_UART_TIMEOUT_EN to discard the key after TIMEOUT_CYC idle cycles.
module rsa_uart_bridge
  import rsa_uart_pkg::*;
#(
  parameter int          KEY_BITS    = 256,
  parameter int          OUT_BYTES   = KEY_BITS / 8 - 1,
  parameter logic [31:0] TIMEOUT_CYC = 32'h0FFF_FFFF,
  parameter logic [4:0]  RX_BASE     = RX_ADDR,
  parameter logic [4:0]  TX_BASE     = TX_ADDR,
  parameter logic [4:0]  STATUS_BASE = STATUS_ADDR,
  parameter int          RX_OK_BIT   = RX_OK,
  parameter int          TX_OK_BIT   = TX_OK
) (
  input  logic                avm_clk,
  input  logic                avm_rst,
  rsa_uart_bridge_if.master   avm,
  output logic                core_start,
  output logic [KEY_BITS-1:0] core_a,
  output logic [KEY_BITS-1:0] core_d,
  output logic [KEY_BITS-1:0] core_n,
  input  logic [KEY_BITS-1:0] core_result,
  input  logic                core_finished,
  output logic [2:0]          state_o,
  output logic                key_valid
);
  localparam int NB = KEY_BITS / 8;
  state_t state_q, state_d;
  phase_t ph_q, ph_d;
  logic [15:0] idx_q, idx_d, tx_q, tx_d;
  logic [KEY_BITS-1:0] n_q, n_d, d_q, d_d, a_q, a_d, res_q, res_d, mask, val;
  logic kv_q, kv_d, start_q, start_d;
  logic load, nxt_read, nxt_write, accept, tmo, last;
  logic [4:0] nxt_addr;
  logic [31:0] nxt_wdata;
  logic [18:0] byte_sh;
  logic unused_bits;
  assign unused_bits = ^{avm.readdata, TIMEOUT_CYC};
`ifdef RSA_UART_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic idle_cnt;
  always_comb begin
    idle_cnt = state_q == POLL_RX && ph_q == PH_DATA && idx_q == 16'(NB - 1);
    tmo      = idle_cnt && idle_q == TIMEOUT_CYC - 32'd1;
    idle_d   = idle_cnt && !tmo ? idle_q + 32'd1 : '0;
  end
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) idle_q <= '0;
    else idle_q <= idle_d;
  end
`else
  assign tmo = 1'b0;
`endif
  rsa_avm_port #(.RST_ADDR(STATUS_BASE)) u_port (
    .avm_clk, .avm_rst, .avm, .load, .nxt_read, .nxt_write, .nxt_addr, .nxt_wdata, .accept
  );
  always_comb begin
    state_d = state_q; ph_d = ph_q; idx_d = idx_q; tx_d = tx_q; kv_d = kv_q;
    n_d = n_q; d_d = d_q; a_d = a_q; res_d = res_q;
    load = 1'b0; nxt_read = 1'b1; nxt_write = 1'b0; nxt_addr = STATUS_BASE; nxt_wdata = '0;
    byte_sh = {idx_q, 3'b000};
    mask = KEY_BITS'(8'hFF) << byte_sh;
    val = KEY_BITS'(avm.readdata[7:0]) << byte_sh;
    last = idx_q == '0 && ph_q == PH_DATA;
    // a timeout pre-empts a status read accepted in the same cycle; the pending read is reissued
    if (tmo) begin
      n_d = '0; d_d = '0; a_d = '0; res_d = '0; kv_d = 1'b0;
      ph_d = PH_N; idx_d = 16'(NB - 1); load = accept;
    end else begin
      case (state_q)
        POLL_RX: if (accept) begin
          load = 1'b1;
          state_d = avm.readdata[RX_OK_BIT] ? READ_RX : POLL_RX;
          nxt_addr = avm.readdata[RX_OK_BIT] ? RX_BASE : STATUS_BASE;
        end
        READ_RX: if (accept) begin
          load = 1'b1;
          n_d = ph_q == PH_N ? (n_q & ~mask) | val : n_q;
          d_d = ph_q == PH_D ? (d_q & ~mask) | val : d_q;
          a_d = ph_q == PH_DATA ? (a_q & ~mask) | val : a_q;
          idx_d = idx_q == '0 ? 16'(NB - 1) : idx_q - 16'd1;
          ph_d = idx_q != '0 ? ph_q : ph_q == PH_N ? PH_D : PH_DATA;
          kv_d = kv_q | (idx_q == '0 && ph_q == PH_D);
          state_d = last ? CALC : POLL_RX;
          nxt_read = !last;
        end
        CALC: if (core_finished) begin
          load = 1'b1; res_d = core_result; tx_d = '0; state_d = POLL_TX;
        end
        POLL_TX: if (accept) begin
          load = 1'b1;
          state_d = avm.readdata[TX_OK_BIT] ? WRITE_TX : POLL_TX;
          nxt_read = !avm.readdata[TX_OK_BIT];
          nxt_write = avm.readdata[TX_OK_BIT];
          nxt_addr = avm.readdata[TX_OK_BIT] ? TX_BASE : STATUS_BASE;
          nxt_wdata = {24'b0, res_q[OUT_BYTES*8-1 -: 8]};
        end
        WRITE_TX: if (accept) begin
          load = 1'b1; res_d = res_q << 8; tx_d = tx_q + 16'd1;
          state_d = tx_q == 16'(OUT_BYTES - 1) ? POLL_RX : POLL_TX;
        end
        default: state_d = POLL_RX;
      endcase
    end
    start_d = state_d == CALC && state_q != CALC;
  end
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_q <= POLL_RX; ph_q <= PH_N; idx_q <= 16'(NB - 1); tx_q <= '0;
      kv_q <= 1'b0; start_q <= 1'b0;
      n_q <= '0; d_q <= '0; a_q <= '0; res_q <= '0;
    end else begin
      state_q <= state_d; ph_q <= ph_d; idx_q <= idx_d; tx_q <= tx_d;
      kv_q <= kv_d; start_q <= start_d;
      n_q <= n_d; d_q <= d_d; a_q <= a_d; res_q <= res_d;
    end
  end
  assign core_start = start_q;
  assign core_a = a_q;
  assign core_d = d_q;
  assign core_n = n_q;
  assign state_o = state_q;
  assign key_valid = kv_q;
endmodule

// File: tb/tb_rsa_uart_bridge.sv
// tb_rsa_uart_bridge: UART + modexp-core model with a TX scoreboard around rsa_uart_bridge (32-bit key).
module tb_rsa_uart_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic core_start, key_valid, core_finished = 1'b0;
  logic [31:0] core_a, core_d, core_n, core_result = '0;
  logic [2:0] state_o;
  int n_checks = 0, n_errors = 0;
  logic [7:0] rx_q[$], exp_tx[$];
  logic [31:0] exp_a[$], res_q[$];
  logic [31:0] exp_n = '0, exp_d = '0;
  int tx_deny = 0, stall_left = 0, rx_reads = 0, starts = 0, core_delay = 0;
  bit stall_arm = 0, tx_phase = 0;
  logic acc = 1'b0, acc_wr = 1'b0;
  logic [4:0] acc_addr = '0;
  logic [31:0] acc_wdata = '0, acc_rdata = '0;

  rsa_uart_bridge_if bus();

  rsa_uart_bridge #(.KEY_BITS(32), .OUT_BYTES(3), .TIMEOUT_CYC(32'd100)) dut (
    .avm_clk(clk), .avm_rst(rst), .avm(bus),
    .core_start(core_start), .core_a(core_a), .core_d(core_d), .core_n(core_n),
    .core_result(core_result), .core_finished(core_finished),
    .state_o(state_o), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 3000 && (rx_q.size() != 0 || exp_tx.size() != 0 || core_delay != 0); i++)
      @(negedge clk);
    check(tag, 64'(i < 3000), 64'd1);
  endtask

  // UART slave and modexp core, evaluated on the falling edge
  initial begin
    logic [7:0] b;
    logic [31:0] w;
    bus.waitrequest = 1'b0;
    bus.readdata = '0;
    forever begin
      @(negedge clk);
      if (core_finished) core_finished = 1'b0;
      if (acc) begin
        if (acc_wr) begin
          check("tx_addr", 64'(acc_addr), 64'd4);
          if (exp_tx.size() == 0) check("tx_unexpected", 64'(acc_wr), 64'd0);
          else begin
            b = exp_tx.pop_front();
            check("tx_byte", 64'(acc_wdata), 64'(b));
          end
          if (exp_tx.size() == 0) tx_phase = 0;
        end else if (acc_addr == 5'd0) begin
          if (rx_q.size() != 0) void'(rx_q.pop_front());
          rx_reads++;
        end else if (tx_phase) begin
          if (acc_rdata[6]) check("tx_follow", 64'(bus.write), 64'd1);
          else tx_deny--;
        end
      end
      if (bus.write) check("no_early_write", 64'(tx_deny), 64'd0);
      if (bus.write) check("rw_exclusive", 64'(bus.read), 64'd0);
      if (stall_left > 0) begin
        check("stall_hold", 64'({bus.read, bus.write, bus.address}), 64'({2'b10, 5'd0}));
        stall_left--;
        bus.waitrequest = stall_left > 0;
      end else if (stall_arm && bus.read && bus.address == 5'd0) begin
        stall_arm = 0;
        stall_left = 5;
        bus.waitrequest = 1'b1;
      end
      bus.readdata = bus.address == 5'd8 ? {24'b0, rx_q.size() != 0, tx_deny == 0, 6'b0} :
                     (bus.address == 5'd0 && rx_q.size() != 0) ? {24'b0, rx_q[0]} : 32'h0;
      acc = (bus.read | bus.write) & ~bus.waitrequest & ~rst;
      acc_wr = bus.write;
      acc_addr = bus.address;
      acc_wdata = bus.writedata;
      acc_rdata = bus.readdata;
      if (core_start) begin
        starts++;
        if (exp_a.size() == 0) check("start_unexpected", 64'(core_start), 64'd0);
        else begin
          w = exp_a.pop_front();
          check("core_a", 64'(core_a), 64'(w));
          check("core_n_at_start", 64'(core_n), 64'(exp_n));
          check("core_d_at_start", 64'(core_d), 64'(exp_d));
          core_delay = 4;
        end
      end else if (core_delay > 0) begin
        core_delay--;
        if (core_delay == 0 && res_q.size() != 0) begin
          core_result = res_q.pop_front();
          core_finished = 1'b1;
          tx_phase = 1;
        end
      end
    end
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_read", 64'(bus.read), 64'd1);
    check("rst_addr", 64'(bus.address), 64'd8);
    check("rst_write", 64'(bus.write), 64'd0);
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_key_valid", 64'(key_valid), 64'd0);
    check("rst_start", 64'(core_start), 64'd0);
    // key load: seven bytes must not yet validate the key
    for (int i = 1; i <= 7; i++) rx_q.push_back(8'(i));
    drain("key7_drain");
    repeat (5) @(negedge clk);
    check("key_valid_after7", 64'(key_valid), 64'd0);
    exp_n = 32'h01020304;
    exp_d = 32'h05060708;
    rx_q.push_back(8'h08);
    drain("key8_drain");
    repeat (3) @(negedge clk);
    check("core_n", 64'(core_n), 64'(exp_n));
    check("core_d", 64'(core_d), 64'(exp_d));
    check("key_valid_after8", 64'(key_valid), 64'd1);
    // block 1: stalled RX read on the first data byte, 20 refused TX polls
    stall_arm = 1;
    tx_deny = 20;
    exp_a.push_back(32'hAABBCCDD);
    res_q.push_back(32'h00112233);
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h33);
    rx_q.push_back(8'hAA); rx_q.push_back(8'hBB); rx_q.push_back(8'hCC); rx_q.push_back(8'hDD);
    drain("block1_drain");
    repeat (3) @(negedge clk);
    check("start_pulses1", 64'(starts), 64'd1);
    check("state_back_rx", 64'(state_o), 64'd0);
    check("key_kept1", 64'(key_valid), 64'd1);
    check("rx_reads_once", 64'(rx_reads), 64'd12);
    check("stall_seen", 64'({stall_arm, 32'(stall_left)}), 64'd0);
    check("deny_consumed", 64'(tx_deny), 64'd0);
    // block 2: only the low three result bytes go out
    exp_a.push_back(32'h12345678);
    res_q.push_back(32'hDEADBEEF);
    exp_tx.push_back(8'hAD); exp_tx.push_back(8'hBE); exp_tx.push_back(8'hEF);
    rx_q.push_back(8'h12); rx_q.push_back(8'h34); rx_q.push_back(8'h56); rx_q.push_back(8'h78);
    drain("block2_drain");
    repeat (3) @(negedge clk);
    check("start_pulses2", 64'(starts), 64'd2);
    check("core_a_block2", 64'(core_a), 64'h12345678);
    check("key_kept2", 64'(key_valid), 64'd1);
    repeat (50) @(negedge clk);
    check("key_before_timeout", 64'(key_valid), 64'd1);
    repeat (100) @(negedge clk);
`ifdef RSA_UART_TIMEOUT_EN
    check("timeout_key_valid", 64'(key_valid), 64'd0);
    check("timeout_n", 64'(core_n), 64'd0);
    check("timeout_d", 64'(core_d), 64'd0);
    check("timeout_a", 64'(core_a), 64'd0);
    exp_n = 32'h11121314;
    exp_d = 32'h15161718;
    for (int i = 0; i < 8; i++) rx_q.push_back(8'h11 + 8'(i));
    drain("reload_drain");
    repeat (3) @(negedge clk);
    check("reload_n", 64'(core_n), 64'(exp_n));
    check("reload_d", 64'(core_d), 64'(exp_d));
    check("reload_key_valid", 64'(key_valid), 64'd1);
`else
    check("no_timeout_key_valid", 64'(key_valid), 64'd1);
    check("no_timeout_n", 64'(core_n), 64'h01020304);
    check("no_timeout_d", 64'(core_d), 64'h05060708);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rsa_uart_bridge.md
RSA_UART_BRIDGE -- requirements
Module: rsa_uart_bridge

Interface
REQ-001 SHALL have parameter KEY_BITS, default 256, giving modulus/exponent/block width; must be a multiple of 8 and at least 16; NB = KEY_BITS/8.
REQ-002 SHALL have parameter OUT_BYTES, default NB-1, giving result bytes transmitted per block, range 1..NB.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 32'h0FFF_FFFF, giving idle cycles before key discard.
REQ-004 SHALL have parameters RX_BASE=0, TX_BASE=4, STATUS_BASE=8, RX_OK_BIT=7, TX_OK_BIT=6 (UART register map).
REQ-005 avm_clk  in  1  clock; all logic on rising edge.
REQ-006 avm_rst  in  1  reset, asynchronous, active-high.
REQ-007 avm_address out 5, avm_read out 1, avm_write out 1, avm_writedata out 32, avm_readdata in 32, avm_waitrequest in 1: Avalon-MM master to the UART.
REQ-008 core_start out 1, core_a/core_d/core_n out KEY_BITS: operands to the modexp core.
REQ-009 core_result in KEY_BITS, core_finished in 1: result and completion pulse from the core.
REQ-010 state_o out 3: current FSM state encoding, for debug LEDs.
REQ-011 key_valid out 1: N and D fully loaded.

Function
REQ-012 Transfer rule: avm_read/avm_write and avm_address SHALL hold stable until the cycle avm_waitrequest=0; readdata is sampled only in that cycle; read and write are never both high.
REQ-013 States: POLL_RX=0, READ_RX=1, CALC=2, POLL_TX=3, WRITE_TX=4.
REQ-014 Phase register: PH_N, then PH_D, then PH_DATA; each phase collects NB bytes, MSB first; the byte index wraps to NB-1 on phase change.
REQ-015 POLL_RX: read STATUS_BASE; on accept with readdata[RX_OK_BIT]=1, go to READ_RX and issue a read of RX_BASE; otherwise re-poll.
REQ-016 READ_RX: on accept, store readdata[7:0] at the current byte index of the phase register; index 0 in PH_N advances to PH_D; index 0 in PH_D sets key_valid and advances to PH_DATA; index 0 in PH_DATA goes to CALC; every other case returns to POLL_RX.
REQ-017 core_start SHALL be a single-cycle pulse in the first CALC cycle; core_a/d/n are driven directly from the registers.
REQ-018 CALC: no bus access (read=write=0); on core_finished=1, latch core_result into the shift register and go to POLL_TX; core_finished is ignored in all other states.
REQ-019 POLL_TX: read STATUS_BASE; on accept with readdata[TX_OK_BIT]=1, go to WRITE_TX with write to TX_BASE, writedata = {24'b0, result byte OUT_BYTES-1 (most significant transmitted byte)}.
REQ-020 WRITE_TX: on accept, shift result left 8; after OUT_BYTES writes go to POLL_RX with phase PH_DATA and the key retained; otherwise go to POLL_TX.
REQ-021 Timeout: idle counter increments each cycle in POLL_RX while phase=PH_DATA and the byte index is NB-1; it clears on any RX byte and on leaving POLL_RX; at TIMEOUT_CYC it clears N, D and the data/result registers and key_valid, sets phase PH_N, and clears the counter, all in one cycle.
REQ-022 Timeout and an accepted status read with RX_OK in the same cycle: the timeout SHALL win and the byte is not read.

Reset
REQ-023 On avm_rst: state POLL_RX, phase PH_N, avm_read=1, avm_address=STATUS_BASE, avm_write=0, avm_writedata=0, core_start=0, key_valid=0, all data registers 0, counters 0.
REQ-024 Reset mid-operation SHALL abort immediately, including a pending bus transfer; the core is reset by the same avm_rst.

Configuration
REQ-025 Macro RSA_UART_TIMEOUT_EN: defined, REQ-021/022 apply; undefined, no counter is built and the key is retained until reset.

Structure
REQ-026 Package rsa_uart_pkg SHALL hold the state enum, phase enum, and register-map/bit localparams.
REQ-027 Sub-module rsa_avm_port SHALL hold the single-outstanding Avalon read/write request registers and the accept strobe.

Verification (KEY_BITS=32, OUT_BYTES=3, UART model)
REQ-028 Release reset -> avm_read=1, avm_address=8, avm_write=0, state_o=0, key_valid=0.
REQ-029 RX bytes 01..08 -> core_n=0x01020304, core_d=0x05060708, key_valid=1 after the 8th byte.
REQ-030 Then RX AA BB CC DD -> core_a=0xAABBCCDD, exactly one core_start pulse; core returns 0x00112233 -> TX writes 0x11, 0x22, 0x33 in order; state returns to POLL_RX and key_valid stays 1.
REQ-031 waitrequest held 5 cycles on an RX read -> address/read stable throughout; byte stored once.
REQ-032 TX_OK=0 for 20 polls -> no avm_write asserted; the write follows the first poll with TX_OK=1.
REQ-033 TIMEOUT_CYC=100, key loaded, no RX -> after 100 cycles key_valid=0 and N=D=0; next 8 bytes reload the key.
